prga_scanchain_programmer: RTL and testbench

Synthesizable scan-chain programming engine for the PRGA fabric. It accepts bitstream words from an upstream word source over a valid/ready handshake and serializes them MSB-first onto the fabric programming pins: prog_rst, prog_we, prog_din, prog_done. It drives the same pin group that the programming side of the Caravel harness wires to mprj_io[37:32], and it consumes the chain tail outputs prog_dout and prog_we_o.

---
 rtl/prga_scanchain_programmer.sv | 230 +++++++++++++++++++++++
 tb/tb_prga_scanchain_programmer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_scanchain_programmer.sv
// -----------------------------------------------------------------------------
// prga_scanchain_programmer
//
// Scan-chain programming engine for the PRGA fabric. Bitstream words arrive
// over a valid/ready handshake and are serialized MSB-first onto the fabric
// programming pins. A session is IDLE -> RESET (prog_rst held) -> LOAD
// (shifting) -> DONE. Only the top (CHAIN_LEN mod WORD_W) bits of a partial
// final word are shifted.
//
// Optional feature macro: PRGA_PROG_ECHO_CHECK_EN
//   When defined, prog_dout is sampled on every shifted bit during LOAD. The
//   chain was cleared by prog_rst, so any 1 seen there is an echo failure:
//   error is set (sticky) and the engine parks in ERROR until the next start.
//   When undefined, prog_dout is ignored and error stays 0.
//
// Parameters:
//   WORD_W     width of one bitstream word
//   CHAIN_LEN  scan-chain length in bits (>= 1)
//   RST_CYCLES cycles prog_rst is held after start (>= 1)
//
// Ports:
//   prog_clk    sole clock (also the fabric programming clock)
//   prog_rst_n  asynchronous active-low reset
//   start       single-cycle session request (honoured in IDLE/DONE/ERROR)
//   word_data   bitstream word, MSB shifted first
//   word_valid  word_data valid
//   word_ready  word taken on word_valid && word_ready
//   prog_rst    fabric programming reset
//   prog_we     chain shift enable
//   prog_din    chain serial data
//   prog_done   fabric programmed
//   prog_dout   chain tail data (echo check)
//   prog_we_o   chain tail write enable (reserved, unused)
//   busy        session in progress (RESET or LOAD)
//   error       sticky echo-check failure
//   bit_cnt     bits shifted into the chain this session
// -----------------------------------------------------------------------------
module prga_scanchain_programmer #(
   parameter int WORD_W     = 32,
   parameter int CHAIN_LEN  = 1024,
   parameter int RST_CYCLES = 4
) (
   input  logic                           prog_clk,
   input  logic                           prog_rst_n,
   input  logic                           start,
   input  logic [WORD_W-1:0]              word_data,
   input  logic                           word_valid,
   output logic                           word_ready,
   output logic                           prog_rst,
   output logic                           prog_we,
   output logic                           prog_din,
   output logic                           prog_done,
   input  logic                           prog_dout,
   input  logic                           prog_we_o,
   output logic                           busy,
   output logic                           error,
   output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int SH_W  = $clog2(WORD_W + 1);
   localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [RC_W-1:0]  RST_LAST_C  = RC_W'(RST_CYCLES - 1);
   localparam logic [SH_W-1:0]  WORD_W_C    = SH_W'(WORD_W);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RESET = 3'd1,
      ST_LOAD  = 3'd2,
`ifdef PRGA_PROG_ECHO_CHECK_EN
      ST_ERROR = 3'd4,
`endif
      ST_DONE  = 3'd3
   } state_t;

   state_t             state_r;
   logic [RC_W-1:0]    rst_cnt_r;
   logic [WORD_W-1:0]  shift_r;       // bits still to be driven, MSB next
   logic [SH_W-1:0]    bits_left_r;   // valid bits left in shift_r
   logic               prog_rst_r;
   logic               prog_we_r;
   logic               prog_din_r;
   logic               prog_done_r;
   logic               word_ready_r;
   logic               busy_r;
   logic               error_r;
   logic [CNT_W-1:0]   bit_cnt_r;

   logic [CNT_W-1:0]   cnt_inc_s;     // bit_cnt after counting the bit on the pins
   logic [CNT_W-1:0]   rem_s;         // bits not yet issued to pins or shift_r
   logic [SH_W-1:0]    load_bits_s;   // bits to take from the next word
   logic               last_bit_s;
   logic               accept_s;
   logic               restart_s;
   logic               unused_s;

   // Session bookkeeping derived from the current registered state.
   always_comb begin
      cnt_inc_s = bit_cnt_r + CNT_W'(prog_we_r);
      rem_s     = CHAIN_LEN_C - cnt_inc_s - CNT_W'(bits_left_r);
      if (32'(rem_s) >= 32'(WORD_W)) begin
         load_bits_s = WORD_W_C;
      end else begin
         load_bits_s = SH_W'(rem_s);
      end
      last_bit_s = prog_we_r && (cnt_inc_s == CHAIN_LEN_C);
      accept_s   = word_valid && word_ready_r && (state_r == ST_LOAD);
`ifdef PRGA_PROG_ECHO_CHECK_EN
      restart_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                             (state_r == ST_ERROR));
`else
      restart_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
`endif
   end

   // The tail write enable is reserved; prog_dout is only read by the echo check.
   assign unused_s = ^{prog_we_o, prog_dout};

   // Programming FSM with registered pin outputs.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_r      <= ST_IDLE;
         rst_cnt_r    <= RC_W'(0);
         shift_r      <= WORD_W'(0);
         bits_left_r  <= SH_W'(0);
         prog_rst_r   <= 1'b1;
         prog_we_r    <= 1'b0;
         prog_din_r   <= 1'b0;
         prog_done_r  <= 1'b0;
         word_ready_r <= 1'b0;
         busy_r       <= 1'b0;
         error_r      <= 1'b0;
         bit_cnt_r    <= CNT_W'(0);
      end else if (restart_s) begin
         state_r      <= ST_RESET;
         rst_cnt_r    <= RC_W'(0);
         shift_r      <= WORD_W'(0);
         bits_left_r  <= SH_W'(0);
         prog_rst_r   <= 1'b1;
         prog_we_r    <= 1'b0;
         prog_din_r   <= 1'b0;
         prog_done_r  <= 1'b0;
         word_ready_r <= 1'b0;
         busy_r       <= 1'b1;
         error_r      <= 1'b0;
         bit_cnt_r    <= CNT_W'(0);
      end else begin
         case (state_r)
            ST_IDLE: begin
               prog_rst_r <= 1'b1;
            end
            ST_RESET: begin
               if (rst_cnt_r == RST_LAST_C) begin
                  state_r      <= ST_LOAD;
                  prog_rst_r   <= 1'b0;
                  word_ready_r <= 1'b1;
               end else begin
                  rst_cnt_r <= rst_cnt_r + RC_W'(1);
               end
            end
            ST_LOAD: begin
               bit_cnt_r <= cnt_inc_s;
`ifdef PRGA_PROG_ECHO_CHECK_EN
               if (prog_we_r && prog_dout) begin
                  state_r      <= ST_ERROR;
                  prog_we_r    <= 1'b0;
                  word_ready_r <= 1'b0;
                  busy_r       <= 1'b0;
                  error_r      <= 1'b1;
               end else
`endif
               if (last_bit_s) begin
                  state_r      <= ST_DONE;
                  prog_we_r    <= 1'b0;
                  prog_done_r  <= 1'b1;
                  word_ready_r <= 1'b0;
                  busy_r       <= 1'b0;
               end else if (bits_left_r != SH_W'(0)) begin
                  prog_we_r    <= 1'b1;
                  prog_din_r   <= shift_r[WORD_W-1];
                  shift_r      <= shift_r << 1;
                  bits_left_r  <= bits_left_r - SH_W'(1);
                  // Ready goes up while the final bit of this word is on the pins.
                  word_ready_r <= (bits_left_r == SH_W'(1)) && (rem_s != CNT_W'(0));
               end else if (accept_s) begin
                  prog_we_r    <= 1'b1;
                  prog_din_r   <= word_data[WORD_W-1];
                  shift_r      <= word_data << 1;
                  bits_left_r  <= load_bits_s - SH_W'(1);
                  word_ready_r <= (load_bits_s == SH_W'(1)) &&
                                  (rem_s != CNT_W'(load_bits_s));
               end else begin
                  prog_we_r    <= 1'b0;
                  word_ready_r <= (rem_s != CNT_W'(0));
               end
            end
            ST_DONE: begin
               prog_done_r <= 1'b1;
               prog_rst_r  <= 1'b0;
            end
`ifdef PRGA_PROG_ECHO_CHECK_EN
            ST_ERROR: begin
               error_r    <= 1'b1;
               prog_rst_r <= 1'b0;
            end
`endif
            default: begin
               state_r      <= ST_IDLE;
               prog_rst_r   <= 1'b1;
               prog_we_r    <= 1'b0;
               prog_done_r  <= 1'b0;
               word_ready_r <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   assign word_ready = word_ready_r;
   assign prog_rst   = prog_rst_r;
   assign prog_we    = prog_we_r;
   assign prog_din   = prog_din_r;
   assign prog_done  = prog_done_r;
   assign busy       = busy_r;
   assign error      = error_r;
   assign bit_cnt    = bit_cnt_r;

endmodule

// File: tb/tb_prga_scanchain_programmer.sv
// Directed bench for prga_scanchain_programmer. Two instances share stimulus:
// dut_a has CHAIN_LEN=64 (whole words), dut_b has CHAIN_LEN=40 (partial word).
// sel chooses which instance the driver follows and the checks observe.
module tb_prga_scanchain_programmer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, word_valid, prog_dout, prog_we_o;
   logic [31:0] word_data;
   logic        sel;

   logic a_ready, a_rst, a_we, a_din, a_done, a_busy, a_error;
   logic b_ready, b_rst, b_we, b_din, b_done, b_busy, b_error;
   logic [6:0] a_cnt;
   logic [5:0] b_cnt;

   logic o_ready, o_rst, o_we, o_din, o_done, o_busy, o_error;
   logic [6:0] o_cnt;

   prga_scanchain_programmer #(.WORD_W(32), .CHAIN_LEN(64), .RST_CYCLES(4)) dut_a (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .word_data(word_data),
      .word_valid(word_valid), .word_ready(a_ready), .prog_rst(a_rst), .prog_we(a_we),
      .prog_din(a_din), .prog_done(a_done), .prog_dout(prog_dout), .prog_we_o(prog_we_o),
      .busy(a_busy), .error(a_error), .bit_cnt(a_cnt));

   prga_scanchain_programmer #(.WORD_W(32), .CHAIN_LEN(40), .RST_CYCLES(4)) dut_b (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .word_data(word_data),
      .word_valid(word_valid), .word_ready(b_ready), .prog_rst(b_rst), .prog_we(b_we),
      .prog_din(b_din), .prog_done(b_done), .prog_dout(prog_dout), .prog_we_o(prog_we_o),
      .busy(b_busy), .error(b_error), .bit_cnt(b_cnt));

   assign o_ready = sel ? b_ready : a_ready;
   assign o_rst   = sel ? b_rst   : a_rst;
   assign o_we    = sel ? b_we    : a_we;
   assign o_din   = sel ? b_din   : a_din;
   assign o_done  = sel ? b_done  : a_done;
   assign o_busy  = sel ? b_busy  : a_busy;
   assign o_error = sel ? b_error : a_error;
   assign o_cnt   = sel ? {1'b0, b_cnt} : a_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] words [0:1];
   logic        cap [0:127];
   int          cap_n, we_total, first_we, last_we, done_cyc, gap_first, gap_last, rst_seen;
   logic        ready_rel, done_after, busy_after, ready_last, timed_out;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Pulse start, then count the cycles prog_rst stays high.
   task automatic do_start(input logic hold_valid);
      word_valid = hold_valid;
      word_data  = words[0];
      start = 1'b1;
      step();
      start = 1'b0;
      done_after = o_done;
      busy_after = o_busy;
      rst_seen = 0;
      while (o_rst && rst_seen < 20) begin
         rst_seen++;
         step();
      end
      ready_rel = o_ready;
   endtask

   // Feed nw words (with an optional gap of ready-but-not-valid cycles before
   // word 1) and capture what appears on the chain pins.
   task automatic run_load(input int nw, input int gap, input int echo_bit,
                           input int stop_cnt, input int max_cyc);
      int   wi, gc, cyc;
      logic acc;
      wi = 0; gc = gap; cyc = 0;
      cap_n = 0; we_total = 0; first_we = -1; last_we = -1; done_cyc = -1;
      gap_first = -1; gap_last = -1; ready_last = 1'b1; timed_out = 1'b0;
      forever begin
         if (o_done || o_error) begin
            done_cyc = cyc;
            break;
         end
         if (stop_cnt >= 0 && int'(o_cnt) == stop_cnt) break;
         if (cyc >= max_cyc) begin
            timed_out = 1'b1;
            break;
         end
         prog_dout = 1'b0;
         if (o_we) begin
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            we_total++;
            ready_last = o_ready;
            if (cap_n < 128) cap[cap_n] = o_din;
            if (cap_n == echo_bit) prog_dout = 1'b1;
            cap_n++;
         end else if (we_total > 0) begin
            if (gap_first < 0) gap_first = int'(o_cnt);
            gap_last = int'(o_cnt);
         end
         if (wi < nw) begin
            if (wi == 1 && gc > 0) begin
               word_valid = 1'b0;
               if (o_ready) gc--;
            end else begin
               word_valid = 1'b1;
               word_data  = words[wi];
            end
         end else begin
            word_valid = 1'b0;
         end
         acc = word_valid && o_ready;
         step();
         cyc++;
         if (acc) wi++;
      end
      word_valid = 1'b0;
      prog_dout  = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] outs;
      sel = 1'b0;
      rst_n = 1'b0; word_valid = 1'b1; word_data = 32'hDEADBEEF;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      outs = {o_we, o_din, o_done, o_ready, o_busy, o_error, 1'b0};
      checks++; if (o_rst !== 1'b1) begin errors++; $display("FAIL reset_prog_rst: got %b expected 1", o_rst); end
      checks++; if (outs !== 7'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 0000000", outs); end
      checks++; if (o_cnt !== 7'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", o_cnt); end
      rst_n = 1'b1;
      step(); step(); step();
      checks++; if (o_rst !== 1'b1) begin errors++; $display("FAIL idle_prog_rst: got %b expected 1", o_rst); end
      checks++; if ({o_busy, o_ready, o_we} !== 3'b000) begin errors++; $display("FAIL idle_no_session: got %b expected 000", {o_busy, o_ready, o_we}); end
      word_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [63:0] got;
      sel = 1'b0;
      words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
      do_start(1'b1);
      checks++; if (busy_after !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy_after); end
      checks++; if (rst_seen != 4) begin errors++; $display("FAIL b2b_rst_cycles: got %0d expected 4", rst_seen); end
      checks++; if (ready_rel !== 1'b1) begin errors++; $display("FAIL b2b_ready_first: got %b expected 1", ready_rel); end
      run_load(2, 0, -1, -1, 300);
      for (int i = 0; i < 64; i++) got[63-i] = cap[i];
      checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got timeout expected done"); end
      checks++; if (first_we != 1) begin errors++; $display("FAIL b2b_first_bit: got cycle %0d expected 1", first_we); end
      checks++; if (we_total != 64 || last_we - first_we + 1 != 64) begin errors++; $display("FAIL b2b_we_run: got %0d bits over %0d cycles expected 64/64", we_total, last_we - first_we + 1); end
      checks++; if (got !== {32'hDEADBEEF, 32'h12345678}) begin errors++; $display("FAIL b2b_bits: got %h expected deadbeef12345678", got); end
      checks++; if (done_cyc != last_we + 1 || o_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got cycle %0d done %b expected %0d 1", done_cyc, o_done, last_we + 1); end
      checks++; if (o_cnt !== 7'd64) begin errors++; $display("FAIL b2b_bit_cnt: got %0d expected 64", o_cnt); end
      checks++; if (ready_last !== 1'b0) begin errors++; $display("FAIL b2b_ready_last: got %b expected 0", ready_last); end
      checks++; if ({o_we, o_ready, o_busy, o_rst} !== 4'b0000) begin errors++; $display("FAIL b2b_done_pins: got %b expected 0000", {o_we, o_ready, o_busy, o_rst}); end
   endtask

   task automatic test_partial_word();
      logic [39:0] got;
      sel = 1'b1;
      words[0] = 32'hFFFFFFFF; words[1] = 32'hA5000000;
      do_start(1'b0);
      checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL partial_restart_done: got %b expected 0", done_after); end
      checks++; if (rst_seen != 4) begin errors++; $display("FAIL partial_rst_cycles: got %0d expected 4", rst_seen); end
      run_load(2, 0, -1, -1, 300);
      for (int i = 0; i < 40; i++) got[39-i] = cap[i];
      checks++; if (timed_out) begin errors++; $display("FAIL partial_timeout: got timeout expected done"); end
      checks++; if (we_total != 40) begin errors++; $display("FAIL partial_count: got %0d expected 40", we_total); end
      checks++; if (got !== {32'hFFFFFFFF, 8'hA5}) begin errors++; $display("FAIL partial_bits: got %h expected ffffffffa5", got); end
      checks++; if ({o_done, o_ready} !== 2'b10) begin errors++; $display("FAIL partial_done: got done,ready %b expected 10", {o_done, o_ready}); end
      checks++; if (o_cnt !== 7'd40) begin errors++; $display("FAIL partial_bit_cnt: got %0d expected 40", o_cnt); end
      step(); step();
      checks++; if ({o_done, o_ready, o_we} !== 3'b100) begin errors++; $display("FAIL partial_hold: got %b expected 100", {o_done, o_ready, o_we}); end
   endtask

   task automatic test_valid_gap();
      logic [63:0] got;
      sel = 1'b0;
      do_reset();
      words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
      do_start(1'b0);
      run_load(2, 3, -1, -1, 300);
      for (int i = 0; i < 64; i++) got[63-i] = cap[i];
      checks++; if (timed_out) begin errors++; $display("FAIL gap_timeout: got timeout expected done"); end
      checks++; if ((last_we - first_we + 1) - we_total != 3) begin errors++; $display("FAIL gap_bubble: got %0d idle cycles expected 3", (last_we - first_we + 1) - we_total); end
      checks++; if (got !== {32'hDEADBEEF, 32'h12345678}) begin errors++; $display("FAIL gap_bits: got %h expected deadbeef12345678", got); end
      checks++; if (gap_first != 32 || gap_last != 32) begin errors++; $display("FAIL gap_cnt_pause: got %0d..%0d expected 32..32", gap_first, gap_last); end
      checks++; if (o_done !== 1'b1 || o_cnt !== 7'd64) begin errors++; $display("FAIL gap_done: got done %b cnt %0d expected 1 64", o_done, o_cnt); end
   endtask

   task automatic test_echo_check();
      sel = 1'b0;
      words[0] = 32'h00000000; words[1] = 32'h00000000;
      do_start(1'b0);
      run_load(2, 0, 10, -1, 300);
      checks++; if (timed_out) begin errors++; $display("FAIL echo_timeout: got timeout expected end"); end
`ifdef PRGA_PROG_ECHO_CHECK_EN
      checks++; if (o_error !== 1'b1 || cap_n != 11) begin errors++; $display("FAIL echo_error: got error %b after %0d bits expected 1 after 11", o_error, cap_n); end
      checks++; if ({o_we, o_done, o_ready} !== 3'b000) begin errors++; $display("FAIL echo_stop: got %b expected 000", {o_we, o_done, o_ready}); end
      step(); step();
      checks++; if ({o_error, o_done, o_we} !== 3'b100) begin errors++; $display("FAIL echo_sticky: got %b expected 100", {o_error, o_done, o_we}); end
`else
      checks++; if (o_done !== 1'b1 || o_cnt !== 7'd64) begin errors++; $display("FAIL echo_off_done: got done %b cnt %0d expected 1 64", o_done, o_cnt); end
      checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL echo_off_error: got %b expected 0", o_error); end
`endif
   endtask

   task automatic test_mid_reset();
      logic [63:0] got;
      sel = 1'b0;
      words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
      do_start(1'b0);
      run_load(2, 0, -1, 20, 300);
      checks++; if (o_cnt !== 7'd20 || o_busy !== 1'b1) begin errors++; $display("FAIL mid_reached: got cnt %0d busy %b expected 20 1", o_cnt, o_busy); end
      rst_n = 1'b0;
      #1;
      checks++; if ({o_rst, o_we, o_din, o_done, o_ready, o_busy, o_error} !== 7'b1000000) begin errors++; $display("FAIL mid_async: got %b expected 1000000", {o_rst, o_we, o_din, o_done, o_ready, o_busy, o_error}); end
      checks++; if (o_cnt !== 7'd0) begin errors++; $display("FAIL mid_bit_cnt: got %0d expected 0", o_cnt); end
      step();
      rst_n = 1'b1;
      step();
      do_start(1'b0);
      run_load(2, 0, -1, -1, 300);
      for (int i = 0; i < 64; i++) got[63-i] = cap[i];
      checks++; if (o_done !== 1'b1 || o_cnt !== 7'd64) begin errors++; $display("FAIL mid_rerun_done: got done %b cnt %0d expected 1 64", o_done, o_cnt); end
      checks++; if (got !== {32'hDEADBEEF, 32'h12345678}) begin errors++; $display("FAIL mid_rerun_bits: got %h expected deadbeef12345678", got); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = 32'h0;
      prog_dout = 1'b0; prog_we_o = 1'b0; sel = 1'b0;
      words[0] = 32'h0; words[1] = 32'h0;
      test_reset();
      test_back_to_back();
      test_partial_word();
      test_valid_gap();
      test_echo_check();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
